// File: rtl/decim_pkg.sv
// Default sizing shared by the channel scheduler and the decimate instances behind it.
package decim_pkg;

    localparam int unsigned DEF_NUM_CH          = 4;
    localparam int unsigned DEF_WIDTH           = 16;
    localparam int unsigned DEF_DECIMATE_FACTOR = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at NUM_CH.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_grant
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_CH);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decim_chan_sched.sv
// Time-shares one decimation datapath among NUM_CH streams: one-deep hold per channel,
// round-robin grant into a single output register, per-channel keep-phase tracking.
module decim_chan_sched
    import decim_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DECIMATE_FACTOR = DEF_DECIMATE_FACTOR,
    parameter int unsigned CH_W            = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       chan_en,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    dp_valid,
    input  logic                    dp_ready,
    output logic [WIDTH-1:0]        dp_data,
    output logic [CH_W-1:0]         dp_ch,
    output logic                    dp_keep
);

    localparam int unsigned     PH_W    = $clog2(DECIMATE_FACTOR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIMATE_FACTOR - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] hold_valid_q;
    logic [WIDTH-1:0]  hold_data_q [NUM_CH];
    logic [PH_W-1:0]   phase_q     [NUM_CH];
    logic [CH_W-1:0]   ptr_q;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_grant;
    logic              slot_free;
    logic              fire;

    // Ready depends only on registered hold state, never on dp_ready.
    assign in_ready  = chan_en & ~hold_valid_q & {NUM_CH{~rst}};
    assign req       = hold_valid_q & chan_en;
    assign slot_free = ~dp_valid | dp_ready;
    assign fire      = slot_free & any_grant;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= '0;
            ptr_q        <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                hold_data_q[c] <= '0;
                phase_q[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (!chan_en[c]) begin
                    // Disabling drops any held sample and restarts the decimation phase.
                    hold_valid_q[c] <= 1'b0;
                    phase_q[c]      <= '0;
                end else if (fire && grant[c]) begin
                    hold_valid_q[c] <= 1'b0;
                    phase_q[c]      <= (phase_q[c] == PH_LAST) ? '0 : phase_q[c] + 1'b1;
                end else if (in_valid[c] && in_ready[c]) begin
                    hold_valid_q[c] <= 1'b1;
                    hold_data_q[c]  <= in_data[c*WIDTH +: WIDTH];
                end
            end
            if (fire) begin
                ptr_q <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_data  <= '0;
            dp_ch    <= '0;
            dp_keep  <= 1'b0;
        end else if (slot_free) begin
            if (any_grant) begin
                dp_valid <= 1'b1;
                dp_data  <= hold_data_q[grant_idx];
                dp_ch    <= grant_idx;
                dp_keep  <= (phase_q[grant_idx] == PH_LAST);
            end else begin
                // Payload fields keep their last value while the slot is empty.
                dp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decim_chan_sched.sv
// Randomized bench for decim_chan_sched with a transaction-level reference model.
module tb_decim_chan_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int DF = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   chan_en = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           dp_ready = 1'b0;
    logic [N-1:0]   in_ready;
    logic           dp_valid;
    logic [W-1:0]   dp_data;
    logic [CW-1:0]  dp_ch;
    logic           dp_keep;

    int tests = 0;
    int fails = 0;

    // Reference model: one-deep slot per channel, output slot, grant counts since enable.
    bit           m_full [N];
    logic [W-1:0] m_data [N];
    int           m_nth  [N];
    int           m_ptr  = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_out_data = '0;
    int           m_out_ch = 0;
    bit           m_out_keep = 1'b0;

    logic [W-1:0] log_data[$];
    int           log_ch[$];
    bit           log_keep[$];

    decim_chan_sched #(
        .NUM_CH          (N),
        .WIDTH           (W),
        .DECIMATE_FACTOR (DF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .chan_en  (chan_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .dp_valid (dp_valid),
        .dp_ready (dp_ready),
        .dp_data  (dp_data),
        .dp_ch    (dp_ch),
        .dp_keep  (dp_keep)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        bit             s_rst;
        bit             s_free;
        logic [N-1:0]   s_en;
        logic [N-1:0]   s_xfer;
        logic [N-1:0]   exp_rdy;
        logic [N*W-1:0] s_data;
        int             w;
        int             c;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
            m_nth[i]  = 0;
        end
        @(posedge clk);
        forever begin
            #8;
            s_rst  = rst;
            s_en   = chan_en;
            s_data = in_data;
            s_free = !m_valid || dp_ready;
            for (int i = 0; i < N; i++) exp_rdy[i] = chan_en[i] && !m_full[i] && !rst;
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL mon_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
            end
            s_xfer = in_valid & exp_rdy;
            @(posedge clk);
            #1;
            if (s_rst) begin
                for (int i = 0; i < N; i++) begin
                    m_full[i] = 1'b0;
                    m_nth[i]  = 0;
                end
                m_ptr = 0; m_valid = 1'b0; m_out_data = '0; m_out_ch = 0; m_out_keep = 1'b0;
            end else begin
                w = -1;
                if (s_free) begin
                    for (int i = 0; i < N; i++) begin
                        c = (m_ptr + i) % N;
                        if (w < 0 && s_en[c] && m_full[c]) w = c;
                    end
                    if (w >= 0) begin
                        m_valid    = 1'b1;
                        m_out_data = m_data[w];
                        m_out_ch   = w;
                        m_nth[w]   = m_nth[w] + 1;
                        m_out_keep = (m_nth[w] % DF) == 0;
                        m_full[w]  = 1'b0;
                        m_ptr      = (w + 1) % N;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (!s_en[i]) begin
                        m_full[i] = 1'b0;
                        m_nth[i]  = 0;
                    end else if (s_xfer[i]) begin
                        m_full[i] = 1'b1;
                        m_data[i] = s_data[i*W +: W];
                    end
                end
                if (w >= 0) begin
                    log_data.push_back(dp_data);
                    log_ch.push_back(int'(dp_ch));
                    log_keep.push_back(dp_keep);
                end
            end
            tests++;
            if (dp_valid !== m_valid) begin
                fails++;
                $display("FAIL mon_dp_valid: got %b expected %b at %0t", dp_valid, m_valid, $time);
            end
            tests++;
            if (dp_data !== m_out_data || dp_ch !== CW'(m_out_ch) || dp_keep !== m_out_keep) begin
                fails++;
                $display("FAIL mon_payload: got data=%h ch=%0d keep=%b expected data=%h ch=%0d keep=%b at %0t",
                         dp_data, dp_ch, dp_keep, m_out_data, m_out_ch, m_out_keep, $time);
            end
        end
    end

    task automatic clear_logs();
        log_data.delete();
        log_ch.delete();
        log_keep.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_one(input int ch, input logic [W-1:0] val, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[ch]) begin
                in_valid[ch]       = 1'b1;
                in_data[ch*W +: W] = val;
                ok                 = 1'b1;
            end
        end
        @(negedge clk);
        in_valid[ch] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        chan_en = 4'b1011;
        #1;
        tests++;
        if (in_ready !== 4'b0000 || dp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_init: got ready=%b valid=%b expected 0000/0", in_ready, dp_valid);
        end
        tests++;
        if (dp_data !== '0 || dp_ch !== '0 || dp_keep !== 1'b0) begin
            fails++;
            $display("FAIL reset_init_payload: got %h/%0d/%b expected 0/0/0", dp_data, dp_ch, dp_keep);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 4'b1011) begin
            fails++;
            $display("FAIL reset_release_ready: got %b expected 1011", in_ready);
        end
        chan_en  = 4'hF;
        dp_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            in_valid = 4'hF;
            in_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (dp_valid !== 1'b0 || dp_data !== '0 || dp_ch !== '0 || dp_keep !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got %b/%h/%0d/%b expected 0/0/0/0", dp_valid, dp_data, dp_ch, dp_keep);
        end
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b expected 0000", in_ready);
        end
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 4'hF) begin
            fails++;
            $display("FAIL reset_mid_release: got %b expected 1111", in_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (dp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_discard: got valid=%b expected 0", dp_valid);
        end
    endtask

    task automatic test_single_ch2();
        bit ok;
        do_reset();
        chan_en  = 4'hF;
        dp_ready = 1'b1;
        clear_logs();
        for (int k = 1; k <= 8; k++) begin
            drive_one(2, W'(k), ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL single_timeout: got no ready expected ready for sample %0d", k);
            end
            @(negedge clk);
            tests++;
            if (dp_valid !== 1'b1 || dp_data !== W'(k) || dp_ch !== 2'd2) begin
                fails++;
                $display("FAIL single_latency: got %b/%h/%0d expected 1/%h/2", dp_valid, dp_data, dp_ch, k);
            end
        end
        repeat (4) @(negedge clk);
        tests++;
        if (log_data.size() != 8) begin
            fails++;
            $display("FAIL single_count: got %0d expected 8", log_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (log_data[i] !== W'(i + 1) || log_ch[i] != 2 || log_keep[i] != ((i + 1) % 4 == 0)) begin
                    fails++;
                    $display("FAIL single_seq[%0d]: got %h/%0d/%b expected %h/2/%b", i, log_data[i],
                             log_ch[i], log_keep[i], i + 1, (i + 1) % 4 == 0);
                end
            end
        end
    endtask

    task automatic test_all_busy();
        do_reset();
        chan_en  = 4'hF;
        dp_ready = 1'b1;
        clear_logs();
        repeat (40) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                in_valid[c] = 1'b1;
                if (in_ready[c]) in_data[c*W +: W] = W'($urandom);
            end
        end
        @(negedge clk);
        in_valid = '0;
        repeat (6) @(negedge clk);
        tests++;
        if (log_ch.size() < 40) begin
            fails++;
            $display("FAIL busy_rate: got %0d grants expected at least 40", log_ch.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                tests++;
                if (log_ch[i] != i % 4 || log_keep[i] != ((i / 4) % 4 == 3)) begin
                    fails++;
                    $display("FAIL busy_rr[%0d]: got ch=%0d keep=%b expected ch=%0d keep=%b", i,
                             log_ch[i], log_keep[i], i % 4, (i / 4) % 4 == 3);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int           sent_cnt;
        int           sent_sum;
        int           got_sum;
        logic [W-1:0] ctr;
        do_reset();
        chan_en  = 4'hF;
        clear_logs();
        sent_cnt = 0;
        sent_sum = 0;
        ctr      = 16'h1000;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            dp_ready = !(t >= 4 && t < 9);
            if (t >= 4 && t < 9) begin
                tests++;
                if (dp_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_valid t=%0d: got %b expected 1", t, dp_valid);
                end
            end
            if (t >= 5 && t < 9) begin
                tests++;
                if (in_ready !== 4'b0000) begin
                    fails++;
                    $display("FAIL bp_ready t=%0d: got %b expected 0000", t, in_ready);
                end
            end
            for (int c = 0; c < N; c++) begin
                in_valid[c] = 1'b1;
                if (in_ready[c]) begin
                    in_data[c*W +: W] = ctr;
                    sent_cnt++;
                    sent_sum += int'(ctr);
                    ctr++;
                end
            end
        end
        @(negedge clk);
        in_valid = '0;
        dp_ready = 1'b1;
        repeat (10) @(negedge clk);
        got_sum = 0;
        foreach (log_data[i]) got_sum += int'(log_data[i]);
        tests++;
        if (log_data.size() != sent_cnt || got_sum != sent_sum) begin
            fails++;
            $display("FAIL bp_conserve: got %0d samples sum %0d expected %0d samples sum %0d",
                     log_data.size(), got_sum, sent_cnt, sent_sum);
        end
    endtask

    task automatic test_disable();
        bit           ok;
        logic [W-1:0] exp_d [6];
        bit           exp_k [6];
        exp_d = '{16'h0101, 16'h0102, 16'h0201, 16'h0202, 16'h0203, 16'h0204};
        exp_k = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        chan_en  = 4'hF;
        dp_ready = 1'b1;
        clear_logs();
        drive_one(1, 16'h0101, ok);
        repeat (2) @(negedge clk);
        dp_ready = 1'b0;
        drive_one(1, 16'h0102, ok);
        drive_one(1, 16'h0103, ok);
        tests++;
        if (!ok || in_ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL dis_held: got ok=%b ready=%b expected 1/0", ok, in_ready[1]);
        end
        chan_en = 4'b1101;
        @(negedge clk);
        chan_en = 4'hF;
        #1;
        tests++;
        if (in_ready[1] !== 1'b1) begin
            fails++;
            $display("FAIL dis_dropped: got ready=%b expected 1", in_ready[1]);
        end
        dp_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 4; k++) drive_one(1, 16'h0200 + W'(k), ok);
        repeat (4) @(negedge clk);
        tests++;
        if (log_data.size() != 6) begin
            fails++;
            $display("FAIL dis_count: got %0d expected 6", log_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (log_data[i] !== exp_d[i] || log_ch[i] != 1 || log_keep[i] != exp_k[i]) begin
                    fails++;
                    $display("FAIL dis_seq[%0d]: got %h/%0d/%b expected %h/1/%b", i, log_data[i],
                             log_ch[i], log_keep[i], exp_d[i], exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        clear_logs();
        repeat (500) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                chan_en[c]  = ($urandom_range(0, 19) != 0);
                in_valid[c] = ($urandom_range(0, 3) != 0);
            end
            in_data  = {$urandom, $urandom};
            dp_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        in_valid = '0;
        chan_en  = 4'hF;
        dp_ready = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (log_data.size() < 100 || dp_valid !== 1'b0 || in_ready !== 4'hF) begin
            fails++;
            $display("FAIL rand_drain: got %0d grants valid=%b ready=%b expected >=100/0/1111",
                     log_data.size(), dp_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_ch2();
        test_all_busy();
        test_backpressure();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule
